// File: rtl/icache_ctrl_if.sv
// Fetch-side and refill-side signal bundle of the instruction cache.
// The slave modport is the cache; master is the PC/IF stage plus the line memory.
interface icache_ctrl_if;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         invalidate;
    logic [31:0]  rdata;
    logic         is_not_cache_stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         mem_valid;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    modport slave (
        input  req_valid, req_addr, invalidate, mem_rdata, mem_valid,
        output rdata, is_not_cache_stall, mem_req, mem_addr, hit_count, miss_count
    );

    modport master (
        output req_valid, req_addr, invalidate, mem_rdata, mem_valid,
        input  rdata, is_not_cache_stall, mem_req, mem_addr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller.
// Hits answer combinationally in the request cycle; a miss latches the line
// address and holds the front end stalled until the 16-byte refill arrives.
module icache_ctrl #(
    parameter int NUM_SETS = 16
) (
    input  logic         clk,
    input  logic         reset,
    icache_ctrl_if.slave bus
);

    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = 28 - IW;

    typedef enum logic [0:0] {
        ST_LOOKUP = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    // Control state (reset)
    state_e                state_q, state_d;
    logic [NUM_SETS-1:0]   valid_q, valid_d;
    logic [27:0]           line_addr_q, line_addr_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;

    // Storage (not reset)
    logic [TW-1:0]         tag_q  [NUM_SETS];
    logic [TW-1:0]         tag_d  [NUM_SETS];
    logic [127:0]          line_q [NUM_SETS];
    logic [127:0]          line_d [NUM_SETS];

    // Request address fields
    logic [1:0]            wsel_s;
    logic [IW-1:0]         idx_s;
    logic [TW-1:0]         tag_s;

    // Refill target fields, taken from the address latched at the miss
    logic [IW-1:0]         fill_idx_s;
    logic [TW-1:0]         fill_tag_s;

    logic                  hit_s;
    logic                  miss_s;
    logic                  fill_s;
    logic [127:0]          sel_line_s;

    assign wsel_s     = bus.req_addr[3:2];
    assign idx_s      = bus.req_addr[4+IW-1:4];
    assign tag_s      = bus.req_addr[31:4+IW];
    assign fill_idx_s = line_addr_q[IW-1:0];
    assign fill_tag_s = line_addr_q[27:IW];

    // Lookup result: a hit is only possible while the FSM is looking up
    always_comb begin
        hit_s  = 1'b0;
        miss_s = 1'b0;
        fill_s = 1'b0;
        if (bus.req_valid && (state_q == ST_LOOKUP)) begin
            if (valid_q[idx_s] && (tag_q[idx_s] == tag_s)) begin
                hit_s = 1'b1;
            end else begin
                miss_s = 1'b1;
            end
        end else begin
            hit_s  = 1'b0;
            miss_s = 1'b0;
        end
        if ((state_q == ST_REFILL) && bus.mem_valid) begin
            fill_s = 1'b1;
        end else begin
            fill_s = 1'b0;
        end
    end

    // State register with synchronous reset; abandons any refill in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOOKUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a late mem_valid in LOOKUP is simply not consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOOKUP: begin
                if (miss_s) begin
                    state_d = ST_REFILL;
                end else begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_REFILL: begin
                if (bus.mem_valid) begin
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            default: begin
                state_d = ST_LOOKUP;
            end
        endcase
    end

    // Valid bits, miss address latch and event counters
    always_comb begin
        valid_d     = valid_q;
        line_addr_d = line_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (fill_s) begin
            valid_d[fill_idx_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
        // Invalidate wins over a coincident fill: the line lands but stays invalid
        if (bus.invalidate) begin
            valid_d = '0;
        end else begin
            valid_d = valid_d;
        end
        if (miss_s) begin
            line_addr_d = bus.req_addr[31:4];
            miss_cnt_d  = miss_cnt_q + 32'd1;
        end else begin
            line_addr_d = line_addr_q;
            miss_cnt_d  = miss_cnt_q;
        end
        if (hit_s) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            line_addr_q <= 28'd0;
            hit_cnt_q   <= 32'd0;
            miss_cnt_q  <= 32'd0;
        end else begin
            valid_q     <= valid_d;
            line_addr_q <= line_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag and data array write on refill completion
    always_comb begin
        tag_d  = tag_q;
        line_d = line_q;
        if (fill_s) begin
            tag_d[fill_idx_s]  = fill_tag_s;
            line_d[fill_idx_s] = bus.mem_rdata;
        end else begin
            tag_d  = tag_q;
            line_d = line_q;
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

    // Outputs: refill request from state, instruction word and stall from the lookup
    always_comb begin
        sel_line_s = line_q[idx_s];
        case (wsel_s)
            2'd0:    bus.rdata = sel_line_s[31:0];
            2'd1:    bus.rdata = sel_line_s[63:32];
            2'd2:    bus.rdata = sel_line_s[95:64];
            2'd3:    bus.rdata = sel_line_s[127:96];
            default: bus.rdata = sel_line_s[31:0];
        endcase
        bus.is_not_cache_stall = !bus.req_valid || hit_s;
        bus.mem_req            = (state_q == ST_REFILL);
        bus.mem_addr           = {line_addr_q, 4'b0000};
        bus.hit_count          = hit_cnt_q;
        bus.miss_count         = miss_cnt_q;
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios followed by random
// fetches, all checked against a line-address-level cache model and a
// synthetic instruction memory defined by a pure function of the address.
module tb_icache_ctrl;

    localparam int SETS = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icache_ctrl_if bus ();

    icache_ctrl #(.NUM_SETS(SETS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: which memory line each set currently holds
    bit          mdl_valid [SETS];
    logic [27:0] mdl_line  [SETS];
    logic [31:0] mdl_hits;
    logic [31:0] mdl_misses;

    // Synthetic instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        logic [127:0] l;
        logic [1:0]   k2;
        for (int k = 0; k < 4; k++) begin
            k2 = 2'(k);
            l[32*k +: 32] = mem_word({la, k2, 2'b00});
        end
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt();
        chk("hit_count", bus.hit_count, mdl_hits);
        chk("miss_count", bus.miss_count, mdl_misses);
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < SETS; i++) mdl_valid[i] = 1'b0;
    endtask

    // One LOOKUP-state fetch cycle; h reports the model's hit decision
    task automatic lookup(input logic [31:0] a, input bit inv, output bit h);
        int ix;
        ix = int'(a[7:4]);
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.invalidate = inv;
        bus.mem_valid  = 1'b0;
        @(negedge clk);
        h = mdl_valid[ix] && (mdl_line[ix] == a[31:4]);
        chk_cnt();
        chk("lk_stall", {31'd0, bus.is_not_cache_stall}, {31'd0, h});
        chk("lk_mem_req", {31'd0, bus.mem_req}, 32'd0);
        if (h) begin
            chk("lk_rdata", bus.rdata, mem_word(a));
            mdl_hits++;
        end else begin
            mdl_misses++;
        end
        if (inv) mdl_clear();
        @(posedge clk); #1;
        bus.invalidate = 1'b0;
    endtask

    // REFILL cycles: lat cycles of waiting, then the mem_valid cycle
    task automatic refill(input logic [27:0] la, input int lat, input bit inv,
                          input logic [31:0] during_addr);
        bus.req_valid = 1'b1;
        bus.req_addr  = during_addr;
        for (int i = 0; i <= lat; i++) begin
            bus.mem_valid  = (i == lat);
            bus.mem_rdata  = (i == lat) ? mem_line(la) : ~mem_line(la);
            bus.invalidate = (i == lat) && inv;
            @(negedge clk);
            chk_cnt();
            chk("rf_mem_req", {31'd0, bus.mem_req}, 32'd1);
            chk("rf_mem_addr", bus.mem_addr, {la, 4'b0000});
            chk("rf_stall", {31'd0, bus.is_not_cache_stall}, 32'd0);
            @(posedge clk); #1;
        end
        bus.mem_valid  = 1'b0;
        bus.invalidate = 1'b0;
        if (inv) begin
            mdl_clear();
        end else begin
            mdl_valid[int'(la[3:0])] = 1'b1;
            mdl_line[int'(la[3:0])]  = la;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int lat);
        bit h;
        lookup(a, 1'b0, h);
        if (!h) begin
            refill(a[31:4], lat, 1'b0, a);
            lookup(a, 1'b0, h);
        end
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.mem_valid = 1'b0;
        @(negedge clk);
        chk_cnt();
        chk("idle_stall", {31'd0, bus.is_not_cache_stall}, 32'd1);
        chk("idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit          h;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;

        // Reset with the fetch side quiet
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'd0;
        bus.invalidate = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.mem_rdata  = 128'd0;
        mdl_clear();
        mdl_hits   = 32'd0;
        mdl_misses = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk_cnt();
        chk("rst_stall", {31'd0, bus.is_not_cache_stall}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // First fetch at 0x0 with memory latency 3, then the rest of the line
        fetch(32'h0000_0000, 3);
        fetch(32'h0000_0004, 0);
        fetch(32'h0000_0008, 0);
        fetch(32'h0000_000C, 0);
        fetch(32'h0000_000C, 0);

        // Same index, different tag, and back
        fetch(32'h0000_0100, 1);
        fetch(32'h0000_0000, 0);

        // Invalidate on a hit still hits; afterwards everything misses
        lookup(32'h0000_0000, 1'b1, h);
        // PC moves to 0x40 during the refill of 0x0
        lookup(32'h0000_0000, 1'b0, h);
        refill(28'h000_0000, 2, 1'b0, 32'h0000_0040);
        lookup(32'h0000_0040, 1'b0, h);
        refill(28'h000_0004, 1, 1'b0, 32'h0000_0040);
        lookup(32'h0000_0040, 1'b0, h);
        lookup(32'h0000_0000, 1'b0, h);

        // Invalidate coincident with the fill strobe
        lookup(32'h0000_0080, 1'b0, h);
        refill(28'h000_0008, 2, 1'b1, 32'h0000_0080);
        fetch(32'h0000_0080, 0);

        // Reset in the middle of a refill, then a stale strobe
        lookup(32'h0000_0200, 1'b0, h);
        @(negedge clk);
        chk("mid_mem_req", {31'd0, bus.mem_req}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_clear();
        mdl_hits   = 32'd0;
        mdl_misses = 32'd0;
        bus.req_valid = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = mem_line(28'h000_0020);
        @(negedge clk);
        chk("rst2_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst2_mem_addr", bus.mem_addr, 32'd0);
        chk_cnt();
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        idle();
        fetch(32'h0000_0200, 1);

        // Random fetches over a small address pool to mix hits and conflicts
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle();
            end else begin
                a = {22'd0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                lookup(a, $urandom_range(0, 15) == 0, h);
                if (!h) begin
                    lat = $urandom_range(0, 3);
                    d = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1023), 2'b00} : a;
                    refill(a[31:4], lat, $urandom_range(0, 7) == 0, d);
                end
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
